// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1-3 stop bits.
// Bit period is (limit+1) clk cycles; the limit is shadowed and latched per frame.
//
// state  | meaning
// IDLE   | line high, s_ready follows cr_tx_en
// START  | start bit (tx=0)
// DATA   | eight data bits, LSB first
// PARITY | optional parity bit
// STOP   | one to three stop bits (tx=1)
module uart_tx (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cr_pbit,
    input  logic        cr_ptype,
    input  logic [1:0]  cr_sbit,
    input  logic [31:0] cr_baud_limit,
    input  logic        cr_baud_update,
    input  logic        cr_tx_en,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        tx,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [31:0] RESET_LIMIT = 32'd433;

    state_t      state;
    logic [31:0] shadow_limit;
    logic [31:0] active_limit;
    logic [31:0] baud_cnt;
    logic [7:0]  data_q;
    logic        pbit_q;
    logic        ptype_q;
    logic [1:0]  sbit_q;
    logic [2:0]  bit_idx;
    logic [1:0]  stop_idx;
    logic        tick;
    logic        xfer;
    logic        last_stop;

    assign s_ready = (state == IDLE) && cr_tx_en;
    assign busy    = (state != IDLE);
    assign xfer    = s_valid && s_ready;
    assign tick    = (baud_cnt == active_limit);

    // sbit codes 10 and 11 both mean three stop bits
    always_comb begin
        last_stop = 1'b0;
        case (sbit_q)
            2'b00:   last_stop = (stop_idx == 2'd0);
            2'b01:   last_stop = (stop_idx == 2'd1);
            default: last_stop = (stop_idx == 2'd2);
        endcase
    end

    assign frame_done = (state == STOP) && tick && last_stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_limit <= RESET_LIMIT;
        end else if (cr_baud_update) begin
            shadow_limit <= cr_baud_limit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tx           <= 1'b1;
            baud_cnt     <= 32'd0;
            bit_idx      <= 3'd0;
            stop_idx     <= 2'd0;
            active_limit <= RESET_LIMIT;
            data_q       <= 8'd0;
            pbit_q       <= 1'b0;
            ptype_q      <= 1'b0;
            sbit_q       <= 2'd0;
        end else begin
            if (state != IDLE) begin
                baud_cnt <= tick ? 32'd0 : baud_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (xfer) begin
                        data_q       <= s_data;
                        pbit_q       <= cr_pbit;
                        ptype_q      <= cr_ptype;
                        sbit_q       <= cr_sbit;
                        // same-cycle update bypasses the shadow register
                        active_limit <= cr_baud_update ? cr_baud_limit : shadow_limit;
                        baud_cnt     <= 32'd0;
                        tx           <= 1'b0;
                        state        <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        bit_idx <= 3'd0;
                        tx      <= data_q[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
                            if (pbit_q) begin
                                tx    <= ptype_q ? ~^data_q : ^data_q;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_idx <= 2'd0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= data_q[bit_idx + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_idx <= 2'd0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (last_stop) begin
                            stop_idx <= 2'd0;
                            state    <= IDLE;
                        end else begin
                            stop_idx <= stop_idx + 2'd1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes hand-computed frames, a monitor
// samples tx mid-bit, checks frame length, frame_done placement and start spacing.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cr_pbit = 1'b0;
    logic        cr_ptype = 1'b0;
    logic [1:0]  cr_sbit = 2'b00;
    logic [31:0] cr_baud_limit = 32'd0;
    logic        cr_baud_update = 1'b0;
    logic        cr_tx_en = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        tx;
    logic        busy;
    logic        frame_done;

    uart_tx dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cr_pbit        (cr_pbit),
        .cr_ptype       (cr_ptype),
        .cr_sbit        (cr_sbit),
        .cr_baud_limit  (cr_baud_limit),
        .cr_baud_update (cr_baud_update),
        .cr_tx_en       (cr_tx_en),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // bits[i] is the i-th bit on the line, start bit first
    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          lim;
        int          gap;
        bit          abort;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_active = 1'b0;
    bit   mon_stray = 1'b0;
    bit   done_seen = 1'b0;
    int   mon_cyc = 0;
    int   last_start = 0;
    int   frame_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (mon_active) begin
                check("abort_no_frame_done", {31'd0, done_seen}, 32'd0);
                mon_active = 1'b0;
            end
            mon_stray = 1'b0;
        end else begin
            if (!busy) mon_stray = 1'b0;
            if (busy && !mon_active && !mon_stray) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: busy rose with empty scoreboard (t=%0t)", $time);
                    mon_stray = 1'b1;
                end else begin
                    cur = sb_q.pop_front();
                    mon_active = 1'b1;
                    mon_cyc = 0;
                    done_seen = 1'b0;
                    if (cur.gap > 0) check("start_spacing", cyc - last_start, cur.gap);
                    last_start = cyc;
                end
            end
            if (mon_active) begin
                frame_len = cur.nbits * (cur.lim + 1);
                if (mon_cyc == frame_len) begin
                    check("busy_after_frame", {31'd0, busy}, 32'd0);
                    check("frame_done_seen", {31'd0, done_seen}, {31'd0, !cur.abort});
                    mon_active = 1'b0;
                end else begin
                    if (mon_cyc % (cur.lim + 1) == cur.lim / 2)
                        check($sformatf("tx_bit%0d", mon_cyc / (cur.lim + 1)), {31'd0, tx},
                              {31'd0, cur.bits[mon_cyc / (cur.lim + 1)]});
                    if (frame_done) begin
                        check("frame_done_cycle", mon_cyc, frame_len - 1);
                        done_seen = 1'b1;
                    end
                    mon_cyc++;
                end
            end
        end
    end

    task automatic strobe(input int lim);
        cr_baud_limit = lim;
        cr_baud_update = 1'b1;
        @(posedge clk); #1;
        cr_baud_update = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] bits, input int nbits,
                        input int lim, input int gap, input bit abort, input int upd);
        exp_t e;
        int   n;
        e = '{bits, nbits, lim, gap, abort};
        sb_q.push_back(e);
        s_data = d;
        s_valid = 1'b1;
        if (upd >= 0) begin
            cr_baud_limit = upd;
            cr_baud_update = 1'b1;
        end
        @(negedge clk);
        for (n = 0; !s_ready && n < 20000; n++) @(negedge clk);
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: s_ready=%0b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        cr_baud_update = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 20000 && (sb_q.size() != 0 || mon_active || busy); n++) @(negedge clk);
        if (sb_q.size() != 0 || mon_active || busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d active=%0b busy=%0b required all clear",
                     sb_q.size(), mon_active, busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 0xA5, L=3, no parity, 1 stop
        strobe(3);
        send(8'hA5, 16'h034A, 10, 3, 0, 1'b0, -1);
        wait_idle();

        // 0x07, L=1, even then odd parity; config changes mid-frame are ignored
        strobe(1);
        cr_pbit = 1'b1;
        cr_ptype = 1'b0;
        send(8'h07, 16'h060E, 11, 1, 0, 1'b0, -1);
        wait_idle();
        cr_ptype = 1'b1;
        send(8'h07, 16'h040E, 11, 1, 0, 1'b0, -1);
        cr_ptype = 1'b0;
        cr_sbit = 2'b11;
        cr_pbit = 1'b0;
        wait_idle();

        // L=0, three stop bits, s_valid held across two bytes
        strobe(0);
        cr_sbit = 2'b11;
        sb_q.push_back('{16'h0E78, 12, 0, 0, 1'b0});
        sb_q.push_back('{16'h0F86, 12, 0, 13, 1'b0});
        s_data = 8'h3C;
        s_valid = 1'b1;
        @(negedge clk);
        for (int n = 0; !s_ready && n < 100; n++) @(negedge clk);
        @(posedge clk); #1;
        s_data = 8'hC3;
        cnt = 0;
        for (int n = 0; n < 13; n++) begin
            @(negedge clk);
            if (s_ready) cnt++;
        end
        check("ready_cycles_between", cnt, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        wait_idle();

        // limit change to 7 during DATA: current frame stays at 4 cycles/bit
        cr_sbit = 2'b00;
        strobe(3);
        send(8'h5A, 16'h02B4, 10, 3, 0, 1'b0, -1);
        repeat (10) @(posedge clk);
        #1;
        strobe(7);
        cr_sbit = 2'b01;
        send(8'h81, 16'h0702, 11, 7, 41, 1'b0, -1);
        cr_sbit = 2'b00;
        wait_idle();

        // update strobe coincident with the transfer: frame uses the new limit
        send(8'h01, 16'h0202, 10, 2, 0, 1'b0, 2);
        wait_idle();

        // reset during data bit 4
        strobe(3);
        send(8'hFF, 16'h03FE, 10, 3, 0, 1'b1, -1);
        repeat (21) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        check("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        send(8'h55, 16'h02AA, 10, 433, 0, 1'b0, -1);
        wait_idle();

        // transmitter disabled: no transfer, line stays idle
        cr_tx_en = 1'b0;
        s_data = 8'h99;
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("disabled_s_ready", {31'd0, s_ready}, 32'd0);
        check("disabled_tx", {31'd0, tx}, 32'd1);
        check("disabled_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
        cr_tx_en = 1'b1;

        // disable mid-frame: frame completes, nothing further is sent
        strobe(1);
        send(8'h0F, 16'h021E, 10, 1, 0, 1'b0, -1);
        cr_tx_en = 1'b0;
        s_data = 8'h33;
        s_valid = 1'b1;
        repeat (30) @(negedge clk);
        check("disabled_after_frame_busy", {31'd0, busy}, 32'd0);
        check("disabled_after_frame_tx", {31'd0, tx}, 32'd1);
        check("disabled_after_frame_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port cr_pbit, input, 1 bit: parity bit enable.
REQ-004 The block SHALL have the port cr_ptype, input, 1 bit: parity type; 0 = even, 1 = odd.
REQ-005 The block SHALL have the port cr_sbit, input, 2 bits: stop bit count; 00 = 1, 01 = 2, 10 = 3, 11 = 3.
REQ-006 The block SHALL have the port cr_baud_limit, input, 32 bits: divider limit L; one bit period is L+1 clk cycles.
REQ-007 The block SHALL have the port cr_baud_update, input, 1 bit: single-cycle strobe that loads cr_baud_limit into the shadow register.
REQ-008 The block SHALL have the port cr_tx_en, input, 1 bit: transmitter enable.
REQ-009 The block SHALL have the port s_data, input, 8 bits: byte to send, taken from the TX FIFO.
REQ-010 The block SHALL have the port s_valid, input, 1 bit: s_data is valid.
REQ-011 The block SHALL have the port s_ready, output, 1 bit: block accepts a byte this cycle.
REQ-012 The block SHALL have the port tx, output, 1 bit: serial line, registered, idle high.
REQ-013 The block SHALL have the port busy, output, 1 bit: frame in progress (state != IDLE).
REQ-014 The block SHALL have the port frame_done, output, 1 bit: single-cycle pulse at frame end.

Function
REQ-015 The block SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-016 s_ready SHALL equal (state==IDLE) && cr_tx_en, combinationally; a transfer occurs when s_valid && s_ready.
REQ-017 On a transfer, the block SHALL latch s_data, cr_pbit, cr_ptype, cr_sbit, and the shadow limit into the active limit, then enter START next cycle with tx=0 registered at that same edge.
REQ-018 The baud counter SHALL restart at 0 on frame start, count to the active limit, and produce a tick when count == L; it SHALL wrap to 0 on the tick.
REQ-019 Each bit SHALL last exactly L+1 cycles; L=0 SHALL give a 1-cycle bit.
REQ-020 DATA SHALL send 8 bits LSB first, using a 3-bit index that runs 0..7.
REQ-021 The state after DATA SHALL be PARITY if the latched pbit is 1, else STOP.
REQ-022 The parity bit SHALL be ^data for even parity and ~^data for odd parity.
REQ-023 STOP SHALL drive tx=1 for 1, 2 or 3 bit periods per the latched sbit.
REQ-024 On the final stop tick, the block SHALL go to IDLE and pulse frame_done for 1 cycle.
REQ-025 The block SHALL stay in IDLE for at least 1 cycle between frames, so the start-edge spacing for back-to-back bytes is N_bits*(L+1)+1 cycles, where N_bits = 1+8+p+s.
REQ-026 cr_baud_update SHALL write the shadow limit in any state; the in-flight frame SHALL keep its active limit.
REQ-027 cr_tx_en=0 mid-frame SHALL let the current frame finish and then block new transfers.
REQ-028 Changes to cr_pbit, cr_ptype or cr_sbit mid-frame SHALL NOT affect the current frame.
REQ-029 When cr_baud_update and a transfer happen in the same cycle, the frame SHALL use the new limit, via a bypass of the shadow register.
REQ-030 The block SHALL hold no byte buffer beyond the one frame being sent; backpressure is carried by s_ready only.

Reset
REQ-031 While reset_n=0, the block SHALL hold state=IDLE, tx=1, busy=0, frame_done=0, baud counter=0, and bit index=0.
REQ-032 Reset SHALL set the shadow and active limit to 32'd433 and the latched config to 0.
REQ-033 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously), abort the frame, and emit no frame_done.
REQ-034 After reset release, s_ready SHALL follow cr_tx_en from the first cycle.

Verification
REQ-035 L=3, pbit=0, sbit=00, send 0xA5 -> tx per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; frame 40 cycles; frame_done on the last cycle.
REQ-036 L=1, pbit=1, send 0x07 with ptype=0 -> parity bit 1; with ptype=1 -> parity bit 0; frame 22 cycles each.
REQ-037 L=0, sbit=11, s_valid held with 2 bytes -> 12-cycle frames, start edges 13 cycles apart, s_ready high for exactly 1 cycle between frames.
REQ-038 L=3 frame in flight, then cr_baud_update with limit 7 during DATA -> current frame stays at 4 cycles/bit; next frame runs at 8 cycles/bit.
REQ-039 reset_n pulsed low during bit 4 of DATA -> tx=1 asynchronously, busy=0, no frame_done; the next byte is sent cleanly at limit 433.
REQ-040 cr_tx_en=0 with s_valid=1 -> s_ready=0 and tx stays high; cr_tx_en dropped mid-frame -> that frame completes, and no further transfer occurs.
